// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 key-event queue: parser states, set-2 byte codes,
// Wishbone register map and event/register bit positions.
package ps2_kbd_pkg;

    localparam int unsigned WB_DW  = 32;
    localparam int unsigned WB_AW  = 32;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned EV_W   = 10;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FC = 8'hFC;
    localparam logic [7:0] SC_FF = 8'hFF;
    localparam logic [7:0] SC_E1 = 8'hE1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_NONE   = 2'd3;

    localparam int unsigned EV_EXT_BIT       = 9;
    localparam int unsigned EV_REL_BIT       = 8;
    localparam int unsigned DATA_VALID_BIT   = 31;
    localparam int unsigned STAT_OVF_BIT     = 31;
    localparam int unsigned STAT_FULL_BIT    = 16;
    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    typedef enum logic [1:0] {
        P_IDLE,
        P_GOT_E0,
        P_GOT_F0,
        P_GOT_E0F0
    } parser_state_t;

    typedef struct packed {
        logic             ext;
        logic             rel;
        logic [CODE_W-1:0] code;
    } kbd_event_t;

    // Keyboard housekeeping bytes that carry no key information when seen outside a prefix
    function automatic logic is_dropped_byte(input logic [7:0] b);
        return (b == SC_00) || (b == SC_AA) || (b == SC_EE) || (b == SC_FA) ||
               (b == SC_FC) || (b == SC_FF) || (b == SC_E1);
    endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Wishbone slave bus bundle for the key-event queue.
interface ps2_key_event_queue_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/kbd_event_fifo.sv
// Synchronous FIFO for key events with push/pop/flush; push while full is ignored unless a pop
// frees the slot in the same cycle.
module kbd_event_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           wr_data,
    output logic [W-1:0]           rd_data_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full_c,
    output logic                   empty_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_pop_c  = pop & ~empty_c;
    assign do_push_c = push & (~full_c | do_pop_c);
    assign rd_data_c = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    // Storage has no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (do_push_c && !flush) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scan-code parser feeding an event FIFO read over Wishbone (DATA/STATUS/CTRL).
// Optional build macro KEY_REPEAT_FILTER_EN suppresses typematic repeats of the held key.
module ps2_key_event_queue
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned PREFIX_TIMEOUT = 50000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic [7:0]             scan_code_i,
    input  logic                   scan_vld_i,
    ps2_key_event_queue_if.slave   wb,
    output logic                   irq_o
);
    localparam int unsigned TMR_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PREFIX_TIMEOUT - 1);

    parser_state_t    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             ev_push_c;
    kbd_event_t       ev_c;

    logic             fifo_push_c;
    logic [EV_W-1:0]  fifo_rd_data_c;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full_c;
    logic             fifo_empty_c;

    logic             req_c, pop_c, flush_c, clr_ovf_c, ovf_set_c;
    logic             ack_q, ack_d, err_q, err_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic             ovf_q;
    logic [1:0]       reg_c;
    logic             unused_c;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= P_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Prefix parser: any byte restarts the prefix timer; idle cycles count only while a prefix is pending
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ev_push_c = 1'b0;
        ev_c.ext  = (state_q == P_GOT_E0) || (state_q == P_GOT_E0F0);
        ev_c.rel  = (state_q == P_GOT_F0) || (state_q == P_GOT_E0F0);
        ev_c.code = scan_code_i;
        if (scan_vld_i) begin
            timer_d = '0;
            case (state_q)
                P_IDLE: begin
                    if (scan_code_i == SC_E0)                 state_d = P_GOT_E0;
                    else if (scan_code_i == SC_F0)            state_d = P_GOT_F0;
                    else if (!is_dropped_byte(scan_code_i))   ev_push_c = 1'b1;
                end
                P_GOT_E0: begin
                    if (scan_code_i == SC_F0)      state_d = P_GOT_E0F0;
                    else if (scan_code_i != SC_E0) begin
                        ev_push_c = 1'b1;
                        state_d   = P_IDLE;
                    end
                end
                P_GOT_F0: begin
                    if (scan_code_i == SC_E0)      state_d = P_GOT_E0F0;
                    else if (scan_code_i != SC_F0) begin
                        ev_push_c = 1'b1;
                        state_d   = P_IDLE;
                    end
                end
                P_GOT_E0F0: begin
                    if (scan_code_i != SC_E0 && scan_code_i != SC_F0) begin
                        ev_push_c = 1'b1;
                        state_d   = P_IDLE;
                    end
                end
                default: state_d = P_IDLE;
            endcase
        end else if (state_q != P_IDLE) begin
            if (timer_q == TMR_LAST) begin
                state_d = P_IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    logic       held_vld_q;
    logic       held_ext_q;
    logic [7:0] held_code_q;
    logic       held_match_c;

    assign held_match_c = held_vld_q && (held_ext_q == ev_c.ext) && (held_code_q == ev_c.code);
    assign fifo_push_c  = ev_push_c & ~(held_match_c & ~ev_c.rel);

    // Held-key tracker: a make latches the key, its release forgets it
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            held_vld_q  <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= '0;
        end else if (flush_c) begin
            held_vld_q  <= 1'b0;
        end else if (ev_push_c) begin
            if (!ev_c.rel) begin
                held_vld_q  <= 1'b1;
                held_ext_q  <= ev_c.ext;
                held_code_q <= ev_c.code;
            end else if (held_match_c) begin
                held_vld_q  <= 1'b0;
            end
        end
    end
`else
    assign fifo_push_c = ev_push_c;
`endif

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .push      (fifo_push_c),
        .pop       (pop_c),
        .flush     (flush_c),
        .wr_data   (ev_c),
        .rd_data_c (fifo_rd_data_c),
        .count     (fifo_count),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // Bus decode; a pending response blocks the next request so a held strobe alternates
    always_comb begin
        req_c     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
        reg_c     = wb.wb_adr_i[3:2];
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = '0;
        pop_c     = 1'b0;
        flush_c   = 1'b0;
        clr_ovf_c = 1'b0;
        if (req_c) begin
            case (reg_c)
                REG_DATA: begin
                    if (wb.wb_we_i) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        if (!fifo_empty_c) begin
                            pop_c = 1'b1;
                            dat_d = {1'b1, 21'b0, fifo_rd_data_c};
                        end
                    end
                end
                REG_STATUS: begin
                    if (wb.wb_we_i) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        dat_d = {ovf_q, 14'b0, fifo_full_c, 16'(fifo_count)};
                    end
                end
                REG_CTRL: begin
                    if (wb.wb_we_i) begin
                        ack_d     = 1'b1;
                        flush_c   = wb.wb_dat_i[CTRL_FLUSH_BIT];
                        clr_ovf_c = wb.wb_dat_i[CTRL_CLR_OVF_BIT];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // A drop lost to a same-cycle flush is not an overflow
    assign ovf_set_c = fifo_push_c & fifo_full_c & ~pop_c & ~flush_c;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
            if (ovf_set_c)      ovf_q <= 1'b1;
            else if (clr_ovf_c) ovf_q <= 1'b0;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign irq_o       = ~fifo_empty_c;

    assign unused_c = ^{wb.wb_sel_i, wb.wb_adr_i[WB_AW-1:4], wb.wb_adr_i[1:0],
                        wb.wb_dat_i[WB_DW-1:2]};

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue: directed scenarios then random byte/bus traffic,
// checked against a prefix-flag model of the scan-code rules and a queue model of the FIFO.
module tb_ps2_key_event_queue;
    import ps2_kbd_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_vld = 1'b0;
    logic       irq;

    ps2_key_event_queue_if #(.AW(32), .DW(32)) wb ();

    always #5 clk = ~clk;

    ps2_key_event_queue #(.DEPTH(DEPTH), .PREFIX_TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .scan_code_i (scan_code),
        .scan_vld_i  (scan_vld),
        .wb          (wb),
        .irq_o       (irq)
    );

    typedef struct {
        bit          err;
        logic [31:0] data;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_cnt = 0;
    exp_t eq[$];

    // Reference model state
    logic [9:0] mq[$];
    bit         m_ovf = 0;
    bit         m_pref = 0, m_ext = 0, m_rel = 0;
    int         m_last = 0;
`ifdef KEY_REPEAT_FILTER_EN
    bit         h_vld = 0, h_ext = 0;
    logic [7:0] h_code = 8'h00;
`endif
    logic [7:0] last_make = 8'h1C;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic bit special(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF, 8'hE1};
    endfunction

    function automatic void model_event(input logic [9:0] e);
`ifdef KEY_REPEAT_FILTER_EN
        if (!e[8]) begin
            if (h_vld && h_ext == e[9] && h_code == e[7:0]) return;
            h_vld = 1; h_ext = e[9]; h_code = e[7:0];
        end else if (h_vld && h_ext == e[9] && h_code == e[7:0]) begin
            h_vld = 0;
        end
`endif
        if (mq.size() >= DEPTH) m_ovf = 1;
        else mq.push_back(e);
    endfunction

    // t is the cycle on which the strobe is sampled
    function automatic void model_byte(input logic [7:0] b, input int t);
        if (m_pref && (t - m_last - 1) >= int'(TO)) begin
            m_pref = 0; m_ext = 0; m_rel = 0;
        end
        m_last = t;
        if (b == 8'hE0) begin
            m_ext = 1; m_pref = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1; m_pref = 1;
        end else if (!(!m_pref && special(b))) begin
            model_event({m_ext, m_rel, b});
            m_pref = 0; m_ext = 0; m_rel = 0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        scan_code = b;
        scan_vld  = 1'b1;
        model_byte(b, cyc_cnt + 1);
        @(negedge clk);
        scan_vld  = 1'b0;
        check("irq_after_byte", 32'(irq), 32'(mq.size() != 0));
    endtask

    function automatic exp_t model_access(input bit we, input logic [1:0] rsel, input logic [31:0] wdata);
        exp_t e;
        e.err  = we ? (rsel != 2'd2) : (rsel == 2'd2 || rsel == 2'd3);
        e.data = 32'h0;
        if (!e.err) begin
            if (rsel == 2'd0) begin
                if (mq.size() > 0) e.data = {1'b1, 21'b0, mq.pop_front()};
            end else if (rsel == 2'd1) begin
                e.data = {m_ovf, 14'b0, mq.size() == DEPTH, 16'(mq.size())};
            end else begin
                if (wdata[0]) begin
                    mq.delete();
`ifdef KEY_REPEAT_FILTER_EN
                    h_vld = 0;
`endif
                end
                if (wdata[1]) m_ovf = 0;
            end
        end
        return e;
    endfunction

    task automatic drive_req(input bit we, input logic [1:0] rsel, input logic [31:0] wdata);
        logic [31:0] adr;
        adr      = $urandom;
        adr[3:2] = rsel;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = we ? wdata : $urandom;
        wb.wb_sel_i = 4'($urandom);
    endtask

    task automatic release_bus();
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    task automatic wb_xfer(input bit we, input logic [1:0] rsel, input logic [31:0] wdata);
        eq.push_back(model_access(we, rsel, wdata));
        drive_req(we, rsel, wdata);
        @(negedge clk);
        check("resp_latency", 32'(wb.wb_ack_o | wb.wb_err_o), 32'd1);
        release_bus();
        @(negedge clk);
        check("irq_after_bus", 32'(irq), 32'(mq.size() != 0));
    endtask

    // Monitor: every response pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wb.wb_ack_o || wb.wb_err_o) begin
                if (eq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", wb.wb_ack_o, wb.wb_err_o);
                end else begin
                    e = eq.pop_front();
                    check("resp_err", 32'(wb.wb_err_o), 32'(e.err));
                    check("resp_ack", 32'(wb.wb_ack_o), 32'(!e.err));
                    check("resp_data", wb.wb_dat_o, e.data);
                end
            end else if (wb.wb_dat_o != 32'h0) begin
                check("dat_idle", wb.wb_dat_o, 32'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         r;
        logic [7:0] b;
        release_bus();
        wb.wb_adr_i = 32'h0;
        wb.wb_dat_i = 32'h0;
        wb.wb_sel_i = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
        check("rst_err", 32'(wb.wb_err_o), 32'd0);
        check("rst_dat", wb.wb_dat_o, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Plain make / release, then empty read
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        wb_xfer(0, 2'd0, 0); wb_xfer(0, 2'd0, 0); wb_xfer(0, 2'd0, 0);

        // Extended make / release with status count
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        wb_xfer(0, 2'd1, 0);
        wb_xfer(0, 2'd0, 0); wb_xfer(0, 2'd0, 0);
        wb_xfer(0, 2'd1, 0);

        // Overflow, clear, flush
        for (int i = 0; i <= int'(DEPTH); i++) send_byte(8'h10 + 8'(i));
        wb_xfer(0, 2'd1, 0);
        wb_xfer(1, 2'd2, 32'h2);
        wb_xfer(0, 2'd1, 0);
        wb_xfer(1, 2'd2, 32'h1);
        wb_xfer(0, 2'd1, 0);

        // Prefix timeout boundary: TO idle cycles expires, TO-1 does not
        send_byte(8'hE0); idle(TO); send_byte(8'h1C);
        send_byte(8'hE0); idle(TO - 1); send_byte(8'h1C);
        wb_xfer(0, 2'd0, 0); wb_xfer(0, 2'd0, 0);

        // Error terminations leave the FIFO alone
        send_byte(8'h2A);
        wb_xfer(1, 2'd0, 32'h1); wb_xfer(1, 2'd1, 32'h3); wb_xfer(0, 2'd2, 0);
        wb_xfer(0, 2'd3, 0); wb_xfer(1, 2'd3, 32'h1);
        wb_xfer(0, 2'd1, 0); wb_xfer(0, 2'd0, 0);

        // Held strobe gets a response every second cycle
        eq.push_back(model_access(0, 2'd1, 0));
        eq.push_back(model_access(0, 2'd1, 0));
        drive_req(0, 2'd1, 0);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = wb.wb_ack_o;
        end
        check("held_stb_pattern", 32'(pat), 32'hA);
        release_bus();
        idle(1);

        // Typematic repeat
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        for (int i = 0; i < 5; i++) wb_xfer(0, 2'd0, 0);

        // Random traffic
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                case ($urandom_range(0, 9))
                    0, 1:    b = 8'hE0;
                    2, 3:    b = 8'hF0;
                    4:       b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hE1;
                    5:       b = last_make;
                    default: b = 8'($urandom);
                endcase
                if (b != 8'hE0 && b != 8'hF0 && !special(b)) last_make = b;
                send_byte(b);
                if ($urandom_range(0, 9) == 0) idle($urandom_range(TO - 2, TO + 1));
                else idle($urandom_range(0, 2));
            end else if (r < 78) begin
                wb_xfer(0, 2'd0, 0);
            end else if (r < 86) begin
                wb_xfer(0, 2'd1, 0);
            end else if (r < 92) begin
                wb_xfer(1, 2'd2, 32'($urandom_range(0, 3)));
            end else begin
                case ($urandom_range(0, 3))
                    0:       wb_xfer(1, 2'd0, $urandom);
                    1:       wb_xfer(1, 2'd1, $urandom);
                    2:       wb_xfer(0, 2'd2, 0);
                    default: wb_xfer($urandom_range(0, 1) == 1, 2'd3, $urandom);
                endcase
            end
        end

        for (int i = 0; i < int'(DEPTH) + 2; i++) wb_xfer(0, 2'd0, 0);
        wb_xfer(0, 2'd1, 0);
        idle(3);
        check("scoreboard_drained", 32'(eq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
